uart_tx_buf: RTL and testbench
==============================

UART_TX_BUF -- requirements
Module: uart_tx_buf

Interface
REQ-001 SHALL have parameter DBIT, default 8, the number of data bits per frame.
REQ-002 SHALL have parameter SB_TICK, default 16, the number of s_tick pulses spent in the stop state (16/24/32 give 1/1.5/2 stop bits).
REQ-003 SHALL have parameter FIFO_W, default 2, the FIFO address width; depth is 2^FIFO_W words.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port s_tick, input, 1 bit: one-clk pulse at 16x the baud rate.
REQ-007 SHALL have port wr_en, input, 1 bit: push request for din.
REQ-008 SHALL have port din, input, DBIT bits: word to transmit.
REQ-009 SHALL have port full, output, 1 bit: FIFO holds 2^FIFO_W words.
REQ-010 SHALL have port empty, output, 1 bit: FIFO holds 0 words.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag for a rejected push.
REQ-012 SHALL have port tx_busy, output, 1 bit: serializer not in IDLE.
REQ-013 SHALL have port tx, output, 1 bit: serial line, idle high.

Function
REQ-014 SHALL accept a push on the rising edge where wr_en=1 and full=0; din is written at the write pointer and the pointer increments modulo 2^FIFO_W.
REQ-015 SHALL ignore a push while full=1, even if a pop occurs in the same cycle; FIFO contents stay unchanged and overflow is set to 1.
REQ-016 SHALL allow a push and a pop in the same cycle when 0 < occupancy < 2^FIFO_W; occupancy is unchanged.
REQ-017 SHALL derive full and empty from registered occupancy; a word pushed into an empty FIFO is visible (empty=0) one cycle after the push edge.
REQ-018 SHALL implement a serializer FSM with states IDLE, START, DATA, STOP, plus a 4-bit tick counter s, a bit counter n of width clog2(DBIT), and a DBIT-bit shift register b.
REQ-019 In IDLE, with empty=0, SHALL on the next edge load b from the FIFO head, pop, clear s, and enter START; tx goes low that same edge.
REQ-020 In START, tx=0; on each s_tick s increments; on the s_tick where s=15, SHALL clear s and n and enter DATA.
REQ-021 In DATA, tx=b[0] (LSB first); on the s_tick where s=15, SHALL shift b right by one, clear s, and increment n; if n=DBIT-1 at that point, SHALL enter STOP instead.
REQ-022 In STOP, tx=1; on the s_tick where s=SB_TICK-1, SHALL enter IDLE.
REQ-023 SHALL advance s, n and b only on cycles with s_tick=1; START begins on a clk edge regardless of tick phase.
REQ-024 Back-to-back words: IDLE with empty=0 SHALL start the next frame one clk after the STOP exit, with no extra idle bit.
REQ-025 tx_busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-026 SHALL register tx so that it is glitch-free.
REQ-027 SHALL leave the frame in progress unaffected by pushes.

Reset
REQ-028 On reset=0 SHALL, asynchronously, set the FSM to IDLE, tx=1, tx_busy=0, s=0, n=0, b=0, both pointers 0, occupancy 0, empty=1, full=0 and overflow=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame, drive tx=1 immediately, and discard all buffered words.
REQ-030 overflow SHALL clear only on reset.

Verification
REQ-031 With s_tick every 4 clk, push 0x55 -> tx=0 for 64 clk, then bits 1,0,1,0,1,0,1,0 for 64 clk each, then tx=1 for 64 clk; tx_busy=1 for 640 clk in total.
REQ-032 Push 4 words (0x01, 0x02, 0x03, 0x04) in 4 consecutive cycles while tx is idle -> frames go out in order, each start bit immediately follows the previous stop bit, and empty=1 after the 4th pop.
REQ-033 With FIFO_W=2, push 6 words back-to-back while the first frame is in progress -> word 1 is being transmitted, words 2-5 are buffered (full=1), word 6 is dropped, and overflow=1.
REQ-034 Assert reset=0 during the DATA state of frame 0xA3 -> tx=1 and empty=1 within the same cycle; after release, tx stays 1 until the next push.
REQ-035 Hold s_tick=0 for 1000 clk after a push -> tx=0 and state START persist with s=0; transmission resumes when ticks restart.
REQ-036 Run with SB_TICK=32 and s_tick every 2 clk, send 0xFF -> the stop high level lasts 64 clk before the next start bit.

Source files
------------

// File: rtl/uart_tx_buf.sv
// rtl/uart_tx_buf.sv - buffered UART transmitter: word FIFO feeding a start/data/stop serializer
//
// uart_tx_fifo: small word queue with registered occupancy.
//   clk, reset      clock, asynchronous active-low reset
//   push, wdata     write request and word (refused while full)
//   pop, rdata      read request and head word (rdata is the current head)
//   full, empty     occupancy flags derived from the registered count
//   overflow        sticky, set by a refused push, cleared only by reset
//
// uart_tx_buf: top level.
//   clk             single clock, all state changes on its rising edge
//   reset           asynchronous active-low reset
//   s_tick          one-clk pulse at 16x the baud rate
//   wr_en, din      push request and word to transmit
//   full, empty     FIFO holds 2^FIFO_W / 0 words
//   overflow        sticky flag for a rejected push
//   tx_busy         serializer is in START, DATA or STOP
//   tx              registered serial line, idle high

module uart_tx_fifo #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic          overflow
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  // A push while full is dropped even if a pop frees a slot this same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

module uart_tx_buf #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int FIFO_W  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            wr_en,
  input  logic [DBIT-1:0] din,
  output logic            full,
  output logic            empty,
  output logic            overflow,
  output logic            tx_busy,
  output logic            tx
);

  // The tick counter is 4 bits for the usual 16-tick bit period; it widens
  // only when the stop phase needs more than 16 ticks (1.5 / 2 stop bits).
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [SW-1:0]   s;
  logic [SW-1:0]   s_next;
  logic [NW-1:0]   n;
  logic [NW-1:0]   n_next;
  logic [DBIT-1:0] b;
  logic [DBIT-1:0] b_next;
  logic            tx_next;
  logic            pop;
  logic [DBIT-1:0] head;

  uart_tx_fifo #(
    .DW (DBIT),
    .AW (FIFO_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (wr_en),
    .wdata    (din),
    .pop      (pop),
    .rdata    (head),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  // State and datapath registers. tx is registered from the next-state
  // decode so the line changes on the same edge as the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      s     <= '0;
      n     <= '0;
      b     <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_next;
      s     <= s_next;
      n     <= n_next;
      b     <= b_next;
      tx    <= tx_next;
    end
  end

  // Next-state and datapath. Leaving IDLE does not wait for a tick, so the
  // first start-bit period may be up to one tick interval short.
  always_comb begin
    state_next = state;
    s_next     = s;
    n_next     = n;
    b_next     = b;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          b_next     = head;
          pop        = 1'b1;
          s_next     = '0;
          state_next = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s == SW'(15)) begin
            s_next     = '0;
            n_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == SW'(15)) begin
            s_next = '0;
            b_next = b >> 1;
            n_next = n + 1'b1;
            if (n == NW'(DBIT - 1)) begin
              state_next = STOP;
            end
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s == SW'(SB_TICK - 1)) begin
            s_next     = '0;
            state_next = IDLE;
          end else begin
            s_next = s + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs: line level follows the state being entered, LSB of b in DATA.
  always_comb begin
    tx_busy = (state != IDLE);
    case (state_next)
      IDLE:    tx_next = 1'b1;
      START:   tx_next = 1'b0;
      DATA:    tx_next = b_next[0];
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// tb/tb_uart_tx_buf.sv - directed self-checking bench for uart_tx_buf
`timescale 1ns/1ps
module tb_uart_tx_buf;

  localparam int MAXS = 4000;

  logic       clk = 1'b0;
  logic       reset;
  logic       s_tick;
  logic       wr_en;
  logic [7:0] din;
  logic       full, empty, overflow, tx_busy, tx;
  logic       full2, empty2, overflow2, tx_busy2, tx2;

  always #5 clk = ~clk;

  uart_tx_buf #(.DBIT(8), .SB_TICK(16), .FIFO_W(2)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .wr_en(wr_en), .din(din),
    .full(full), .empty(empty), .overflow(overflow), .tx_busy(tx_busy), .tx(tx)
  );

  uart_tx_buf #(.DBIT(8), .SB_TICK(32), .FIFO_W(2)) dut2 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .wr_en(wr_en), .din(din),
    .full(full2), .empty(empty2), .overflow(overflow2), .tx_busy(tx_busy2), .tx(tx2)
  );

  int checks = 0;
  int errors = 0;

  bit txs  [MAXS];
  bit bzs  [MAXS];
  bit emps [MAXS];
  bit fls  [MAXS];
  bit ovs  [MAXS];
  bit txs2 [MAXS];
  bit bzs2 [MAXS];

  logic [7:0] vec [8];
  int tick_per = 4;
  int ph = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Tick generator: s_tick changes on falling edges only.
  initial begin
    s_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_per == 0) begin
        s_tick = 1'b0;
      end else begin
        ph = (ph + 1 >= tick_per) ? 0 : ph + 1;
        s_tick = (ph == 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic record(input int cnt);
    for (int i = 0; i < cnt && i < MAXS; i++) begin
      @(negedge clk);
      txs[i]  = tx;
      bzs[i]  = tx_busy;
      emps[i] = empty;
      fls[i]  = full;
      ovs[i]  = overflow;
      txs2[i] = tx2;
      bzs2[i] = tx_busy2;
    end
  endtask

  task automatic push_seq(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk);
      wr_en = 1'b1;
      din   = vec[i];
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Returns just after a tick edge T, plus (lead-2) further edges, so a
  // push_seq started next lands its first push one edge before a tick.
  task automatic align_tick(input int lead);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 64 && !hit; i++) begin
      @(posedge clk);
      hit = s_tick;
    end
    check("tick_align", hit, 1);
    for (int i = 0; i < lead - 2; i++) @(posedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic bit get_tx(input bit sel, input int i);
    if (i < 0 || i >= MAXS) return 1'b0;
    return sel ? txs2[i] : txs[i];
  endfunction

  function automatic int find_fall(input int from, input int upto);
    for (int i = (from < 1) ? 1 : from; i < upto; i++)
      if (txs[i-1] == 1'b1 && txs[i] == 1'b0) return i;
    return -1;
  endfunction

  // Mid-bit sampling of a frame whose start bit begins at index f.
  function automatic logic [7:0] decode(input bit sel, input int f, input int bl);
    logic [7:0] d;
    for (int k = 0; k < 8; k++) d[k] = get_tx(sel, f + bl/2 + bl*(k+1));
    return d;
  endfunction

  task automatic check_frames(input string tag, input int nfr, input int len);
    int fk, prev, idx, idle;
    prev = -1;
    idx  = 0;
    for (int k = 0; k < nfr; k++) begin
      fk = find_fall(idx, len);
      check($sformatf("%s_byte%0d", tag, k), decode(0, fk, 64), vec[k]);
      if (k > 0) begin
        idle = 0;
        for (int i = prev + 1; i < fk; i++) if (!bzs[i]) idle++;
        check($sformatf("%s_gap%0d", tag, k), idle, 1);
      end
      prev = fk;
      idx  = fk + 580;
    end
    if (nfr == 4) begin
      check($sformatf("%s_empty_before_pop4", tag), emps[prev-1], 0);
      check($sformatf("%s_empty_after_pop4", tag), emps[prev], 1);
    end else begin
      check($sformatf("%s_no_extra_frame", tag), find_fall(idx, len), 32'hffffffff);
    end
  endtask

  initial begin
    int f, errs, nb, z, hi;
    logic [7:0] d;
    bit e;

    reset = 1'b0;
    wr_en = 1'b0;
    din   = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_tx2", tx2, 1);
    reset = 1'b1;

    // Single 0x55 frame, tick every 4 clk, push aligned to the tick phase.
    vec[0] = 8'h55;
    d = vec[0];
    align_tick(4);
    fork push_seq(1); record(700); join
    f = find_fall(0, 700);
    check("f55_fall_idx", f, 2);
    check("f55_empty_before", emps[0], 1);
    check("f55_empty_after_push", emps[1], 0);
    check("f55_empty_after_pop", emps[2], 1);
    errs = 0;
    nb = 0;
    for (int i = 0; i < 700; i++) begin
      e = (i < 2) ? 1'b1 : (i < 66) ? 1'b0 : (i < 578) ? d[(i-66)/64] : 1'b1;
      if (txs[i] !== e) errs++;
      if (bzs[i] !== (i >= 2 && i < 642)) errs++;
      if (bzs[i]) nb++;
    end
    check("f55_wave_errs", errs, 0);
    check("f55_busy_len", nb, 640);
    z = 0;
    for (int i = 2; i < 700 && txs[i] == 1'b0; i++) z++;
    check("f55_start_len", z, 64);

    // Four words pushed in consecutive cycles while idle.
    vec[0] = 8'h01; vec[1] = 8'h02; vec[2] = 8'h03; vec[3] = 8'h04;
    align_tick(4);
    fork push_seq(4); record(2700); join
    check_frames("b2b", 4, 2700);
    check("b2b_empty_end", emps[2699], 1);

    // Six pushes back to back: one in flight, four buffered, sixth dropped.
    vec[0] = 8'hC1; vec[1] = 8'h52; vec[2] = 8'h93;
    vec[3] = 8'h34; vec[4] = 8'hE5; vec[5] = 8'h76;
    align_tick(4);
    fork push_seq(6); record(3400); join
    check("ovf_full_at4", fls[5], 1);
    check("ovf_clear_before6", ovs[5], 0);
    check("ovf_set_at6", ovs[6], 1);
    check("ovf_still_full", fls[6], 1);
    check_frames("ovf", 5, 3400);
    check("ovf_sticky", ovs[3399], 1);
    check("ovf_empty_end", emps[3399], 1);

    // Reset in the middle of the DATA phase of 0xA3 with two words queued.
    vec[0] = 8'hA3; vec[1] = 8'h11; vec[2] = 8'h22;
    align_tick(4);
    fork push_seq(3); record(300); join
    check("rst_mid_started", txs[2], 0);
    check("rst_mid_tx_before", txs[299], 0);
    check("rst_mid_empty_before", emps[299], 0);
    reset = 1'b0;
    #1;
    check("rst_mid_tx", tx, 1);
    check("rst_mid_empty", empty, 1);
    check("rst_mid_busy", tx_busy, 0);
    check("rst_mid_overflow", overflow, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    record(300);
    z = 0;
    nb = 0;
    for (int i = 0; i < 300; i++) begin
      if (!txs[i]) z++;
      if (bzs[i]) nb++;
    end
    check("rst_after_low_cnt", z, 0);
    check("rst_after_busy_cnt", nb, 0);

    // Ticks stopped: the start bit must hold, then resume cleanly.
    @(posedge clk);
    #1;
    tick_per = 0;
    vec[0] = 8'h69;
    fork push_seq(1); record(1002); join
    hi = 0;
    nb = 0;
    for (int i = 2; i < 1002; i++) begin
      if (txs[i]) hi++;
      if (bzs[i]) nb++;
    end
    check("stall_tx_high_cnt", hi, 0);
    check("stall_busy_cnt", nb, 1000);
    @(posedge clk);
    #1;
    ph = 0;
    tick_per = 4;
    align_tick(2);
    record(700);
    check("stall_last_start", txs[59], 0);
    check("stall_first_data", txs[60], 1);
    check("stall_byte", decode(0, -4, 64), 8'h69);
    check("stall_busy_end", bzs[635], 1);
    check("stall_idle_end", bzs[636], 0);

    // Two stop bits, tick every 2 clk, 0xFF.
    pulse_reset();
    @(posedge clk);
    #1;
    ph = 0;
    tick_per = 2;
    vec[0] = 8'hFF;
    align_tick(2);
    fork push_seq(1); record(450); join
    check("sb32_pre_start", txs2[1], 1);
    check("sb32_start", txs2[2], 0);
    z = 0;
    for (int i = 2; i < 450 && txs2[i] == 1'b0; i++) z++;
    check("sb32_start_len", z, 32);
    nb = 0;
    hi = 0;
    for (int i = 0; i < 450; i++) begin
      if (bzs2[i]) nb++;
      if (bzs2[i] && txs2[i]) hi++;
    end
    check("sb32_busy_len", nb, 352);
    check("sb32_stop_len", hi - 256, 64);
    check("sb32_byte", decode(1, 2, 32), 8'hFF);
    nb = 0;
    for (int i = 0; i < 450; i++) if (bzs[i]) nb++;
    check("sb16_busy_len", nb, 320);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
